// File: rtl/multdiv_divider_if.sv
// rtl/multdiv_divider_if.sv - issue/result bundle shared by the MultDiv divider and its requester
interface multdiv_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_divider.sv
// rtl/multdiv_divider.sv - sequential signed restoring divider, one quotient bit per clock
// Trial subtraction runs on a chain of 8-bit carry-lookahead slices.
module multdiv_divider_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate terms gated by the propagate run above them.
  always_comb begin
    logic ci;
    logic pp;
    c    = '0;
    ci   = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      ci = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        ci = ci | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = ci | (pp & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
endmodule

module multdiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_divider_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int NS = WIDTH / 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sign_q, sign_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic [NS:0]      slice_c;
  logic             no_borrow;
  logic             unused_r_msb;

  // Magnitudes are kept unsigned, so negating the most negative value is exact.
  assign abs_a  = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign abs_b  = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
  assign b_zero = (bus.data_operandB == '0);

  assign trial        = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign unused_r_msb = r_q[WIDTH-1];

  // trial + ~D + 1 across the slice chain; carry out of the top slice means no borrow.
  assign slice_c[0] = 1'b1;
  for (genvar s = 0; s < NS; s++) begin : g_cla
    multdiv_divider_cla8 u_cla8 (
      .a   (trial[8*s +: 8]),
      .b   (~d_q[8*s +: 8]),
      .cin (slice_c[s]),
      .sum (diff[8*s +: 8]),
      .cout(slice_c[s+1])
    );
  end
  assign no_borrow = slice_c[NS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    d_d      = d_q;
    r_d      = r_q;
    sign_d   = sign_q;
    div0_d   = div0_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    // A start pulse always wins: it aborts whatever is in flight without a ready pulse.
    if (bus.ctrl_DIV) begin
      q_d     = abs_a;
      d_d     = abs_b;
      r_d     = '0;
      cnt_d   = '0;
      sign_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div0_d  = b_zero;
      state_d = b_zero ? S_FIX : S_RUN;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          cnt_d = cnt_q + 1'b1;
          if (no_borrow) begin
            r_d = diff;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = trial;
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (div0_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = sign_q ? (~q_q + 1'b1) : q_q;
            exc_d    = 1'b0;
          end
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      sign_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      d_q      <= d_d;
      r_q      <= r_d;
      sign_q   <= sign_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_divider.sv
// tb/tb_multdiv_divider.sv - scoreboard bench for the MultDiv divider
module tb_multdiv_divider;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  multdiv_divider_if #(.WIDTH(W)) dif ();

  multdiv_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   rdy_count = 0;
  logic prev_rdy  = 1'b0;
  logic [W-1:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sbv;
    longint qq;
    if (b == '0) return '0;
    sa  = longint'(signed'(a));
    sbv = longint'(signed'(b));
    qq  = sa / sbv;
    return qq[W-1:0];
  endfunction

  task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = model_div(a, b);
    e.exc = (b == '0);
    e.lat = (b == '0) ? 1 : W + 1;
    sb.push_back(e);
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.data_operandA = a;
    dif.data_operandB = b;
    dif.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    dif.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clock);
      if (dif.data_resultRDY) seen = 1;
      else begin
        @(posedge clock);
        n++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_res"}, dif.data_result, e.res);
    check({tag, "_exc"}, dif.data_exception, e.exc);
    check({tag, "_lat"}, n, e.lat);
    last_res = e.res;
  endtask

  always @(negedge clock) begin
    if (dif.data_resultRDY) rdy_count++;
    if (prev_rdy) check("rdy_pulse", dif.data_resultRDY, 64'd0);
    prev_rdy = dif.data_resultRDY;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] tbl_a[4] = '{-32'sd100, 32'sd100, -32'sd100, 32'sd7};
  logic [W-1:0] tbl_b[4] = '{32'sd7, -32'sd7, -32'sd7, 32'sd9};

  initial begin
    int rc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    dif.data_operandA = '0;
    dif.data_operandB = '0;
    dif.ctrl_DIV      = 1'b0;
    reset             = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_res", dif.data_result, 64'd0);
    check("reset_exc", dif.data_exception, 64'd0);
    check("reset_rdy", dif.data_resultRDY, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    expect_op(32'd100, 32'd7);
    start(32'd100, 32'd7);
    wait_rdy("t1_100_7");
    check("t1_const", dif.data_result, 64'h0000000E);

    // Each op starts in the ready cycle of the previous one; outputs must hold across the start.
    for (int i = 0; i < 4; i++) begin
      expect_op(tbl_a[i], tbl_b[i]);
      start(tbl_a[i], tbl_b[i]);
      check("hold_on_start", dif.data_result, last_res);
      wait_rdy("t2_signs");
    end

    expect_op(32'd5, 32'd0);
    start(32'd5, 32'd0);
    wait_rdy("t3_div0");
    expect_op(32'd6, 32'd3);
    start(32'd6, 32'd3);
    check("t3_hold_exc", dif.data_exception, 64'd1);
    wait_rdy("t3_after_div0");

    expect_op(32'h80000000, 32'hFFFFFFFF);
    start(32'h80000000, 32'hFFFFFFFF);
    wait_rdy("t4_min_m1");
    check("t4_min_m1_const", dif.data_result, 64'h80000000);
    expect_op(32'h80000000, 32'd1);
    start(32'h80000000, 32'd1);
    wait_rdy("t4_min_1");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 50)) : W'($urandom);
      if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
      expect_op(ra, rb);
      start(ra, rb);
      wait_rdy("t_rand");
    end

    // Restart ten edges into an op: only the second op may report.
    @(posedge clock);
    #1;
    rc0 = rdy_count;
    start(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #1;
    expect_op(32'd81, 32'd9);
    start(32'd81, 32'd9);
    wait_rdy("t5_restart");
    repeat (3) @(posedge clock);
    #1;
    check("t5_rdy_count", rdy_count - rc0, 64'd1);

    // ctrl_DIV held high for several edges: the last sampling edge is the real start.
    dif.data_operandA = 32'd20;
    dif.data_operandB = 32'd4;
    dif.ctrl_DIV      = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    expect_op(32'd20, 32'd4);
    start(32'd20, 32'd4);
    wait_rdy("t_held");

    @(posedge clock);
    #1;
    start(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_res", dif.data_result, 64'd0);
    check("t6_async_exc", dif.data_exception, 64'd0);
    check("t6_async_rdy", dif.data_resultRDY, 64'd0);
    rc0 = rdy_count;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("t6_no_rdy", rdy_count - rc0, 64'd0);
    expect_op(32'd12, 32'd4);
    start(32'd12, 32'd4);
    wait_rdy("t6_after_reset");
    check("t6_const", dif.data_result, 64'd3);

    check("sb_drained", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
